// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V instruction-fetch front end.
package riscv_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {F_IDLE, F_FETCH} fetch_state_t;

endpackage

// File: rtl/riscv_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a register-driven head output.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  T                             din,
    output T                             dout,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch queue: credit-limited imem requests, in-order responses, redirect/flush.
// Optional FETCH_PERF_EN adds saturating fetched/dropped counters.
module riscv_fetch_queue
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_data
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_dropped
`endif
);

    localparam int              CNT_W     = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(INSTR_BYTES-1);
    localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);

    fetch_state_t     state;
    logic [XLEN-1:0]  rsp_pc;
    logic [XLEN-1:0]  target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             room;
    logic             issue;
    logic             drop;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    assign target = redirect_pc & WORD_MASK;

    // Buffered plus in-flight (including to-be-dropped) never exceeds DEPTH.
    assign room      = ({1'b0, fifo_cnt} + {1'b0, outstanding}) < (CNT_W+1)'(DEPTH);
    assign req_valid = (state == F_FETCH) && !redirect && room;
    assign issue     = req_valid && req_ready;

    assign drop     = rsp_valid && (redirect || (drop_cnt != '0));
    assign push     = rsp_valid && !drop;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign wr_entry = '{pc: rsp_pc, instr: rsp_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= F_IDLE;
        end else if (state == F_IDLE) begin
            if (fetch_en) state <= F_FETCH;
        end else if (!fetch_en && !(req_valid && !req_ready)) begin
            state <= F_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp_valid);
            if (redirect) begin
                req_addr <= target;
                rsp_pc   <= target;
                drop_cnt <= outstanding - CNT_W'(rsp_valid);
            end else begin
                if (issue) req_addr <= req_addr + STEP;
                if (push)  rsp_pc   <= rsp_pc + STEP;
                if (drop)  drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (wr_entry),
        .dout  (head),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr_pc    = head.pc;
    assign instr_data  = head.instr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_full && !pop));
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
        return (&v) ? v : v + XLEN'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (push) perf_fetched <= sat_inc(perf_fetched);
            if (drop) perf_dropped <= sat_inc(perf_dropped);
        end
    end
`endif

endmodule
